// File: rtl/mbist_march_engine.sv
// March-test MBIST engine (MATS+ / March C-) for a single-port synchronous RAM.
// Define MBIST_DIAG_EN to build first-fail address/element capture and a saturating fail counter.
module mbist_march_engine #(
   parameter int unsigned AWIDTH  = 4,
   parameter int unsigned DWIDTH  = 8,
   parameter int unsigned FCWIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               test_mode,
   input  logic               start,
   input  logic               march_sel,
   output logic [AWIDTH-1:0]  mem_addr,
   output logic [DWIDTH-1:0]  mem_wdata,
   output logic               mem_we,
   output logic               mem_re,
   input  logic [DWIDTH-1:0]  mem_rdata,
   output logic               bist_status,
   output logic               bist_done,
   output logic               bist_pass,
   output logic [AWIDTH-1:0]  fail_addr,
   output logic [2:0]         fail_elem,
   output logic [FCWIDTH-1:0] fail_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state;
   logic                sel_q;
   logic [2:0]          elem;
   logic [AWIDTH-1:0]   addr;
   logic                opi;
   logic                fin;
   logic                op_exp;
   logic                chk_q;
   logic                exp_q;

   logic                two_op, is_read, op_val, down, next_down, elem_last_op, mismatch;
   logic [2:0]          last_elem;
   logic [AWIDTH-1:0]   addr_end;

`ifdef MBIST_DIAG_EN
   logic [2:0]          op_elem;
   logic [AWIDTH-1:0]   addr_q;
   logic [2:0]          elem_q;
`endif

   function automatic logic elem_down(input logic sel, input logic [2:0] e);
      return sel ? (e == 3'd3 || e == 3'd4) : (e == 3'd2);
   endfunction

   // Two-op elements read ~elem[0] then write elem[0]; element 0 is w0, March C- element 5 is r0.
   always_comb begin
      last_elem    = sel_q ? 3'd5 : 3'd2;
      two_op       = (elem != 3'd0) && !(sel_q && elem == 3'd5);
      is_read      = two_op ? !opi : (elem != 3'd0);
      op_val       = two_op ? (opi ? elem[0] : !elem[0]) : 1'b0;
      down         = elem_down(sel_q, elem);
      next_down    = elem_down(sel_q, elem + 3'd1);
      addr_end     = down ? '0 : '1;
      elem_last_op = !two_op || opi;
      mismatch     = chk_q && (mem_rdata != {DWIDTH{exp_q}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || !test_mode) begin
         state       <= IDLE;
         sel_q       <= 1'b0;
         elem        <= '0;
         addr        <= '0;
         opi         <= 1'b0;
         fin         <= 1'b0;
         op_exp      <= 1'b0;
         chk_q       <= 1'b0;
         exp_q       <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
         bist_status <= 1'b0;
         bist_done   <= 1'b0;
         bist_pass   <= 1'b1;
`ifdef MBIST_DIAG_EN
         op_elem     <= '0;
         addr_q      <= '0;
         elem_q      <= '0;
         fail_addr   <= '0;
         fail_elem   <= '0;
         fail_count  <= '0;
`endif
      end else begin
         chk_q <= mem_re;
         exp_q <= op_exp;
`ifdef MBIST_DIAG_EN
         addr_q <= mem_addr;
         elem_q <= op_elem;
`endif
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= RUN;
                  sel_q     <= march_sel;
                  elem      <= '0;
                  addr      <= '0;
                  opi       <= 1'b0;
                  fin       <= 1'b0;
                  bist_done <= 1'b0;
                  bist_pass <= 1'b1;
`ifdef MBIST_DIAG_EN
                  fail_addr  <= '0;
                  fail_elem  <= '0;
                  fail_count <= '0;
`endif
               end
            end
            RUN: begin
               if (!fin) begin
                  bist_status <= 1'b1;
                  mem_addr    <= addr;
                  mem_we      <= !is_read;
                  mem_re      <= is_read;
                  mem_wdata   <= is_read ? '0 : {DWIDTH{op_val}};
                  op_exp      <= op_val;
`ifdef MBIST_DIAG_EN
                  op_elem     <= elem;
`endif
                  if (!elem_last_op) begin
                     opi <= 1'b1;
                  end else begin
                     opi <= 1'b0;
                     if (addr == addr_end) begin
                        if (elem == last_elem) begin
                           fin <= 1'b1;
                        end else begin
                           elem <= elem + 3'd1;
                           addr <= next_down ? '1 : '0;
                        end
                     end else begin
                        addr <= down ? addr - 1'b1 : addr + 1'b1;
                     end
                  end
               end else begin
                  // Last op has left the bus; one more cycle for its read data to return.
                  mem_we    <= 1'b0;
                  mem_re    <= 1'b0;
                  mem_wdata <= '0;
                  state     <= DRAIN;
               end
            end
            DRAIN: begin
               state       <= DONE;
               bist_status <= 1'b0;
               bist_done   <= 1'b1;
            end
            default: state <= IDLE;
         endcase

         if (mismatch) begin
            bist_pass <= 1'b0;
`ifdef MBIST_DIAG_EN
            if (bist_pass) begin
               fail_addr <= addr_q;
               fail_elem <= elem_q;
            end
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
`endif
         end
      end
   end

`ifndef MBIST_DIAG_EN
   assign fail_addr  = '0;
   assign fail_elem  = '0;
   assign fail_count = '0;
`endif

endmodule
